// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: instruction/word widths, default depth
// and a saturating increment helper used by the optional statistics counters.
package fetch_queue_pkg;

    localparam int INSTR_LEN = 32;
    localparam int WORD      = 64;
    localparam int FQ_DEPTH  = 4;

    // Adds a small occupancy value to a 32-bit counter, clamping at all ones.
    function automatic logic [31:0] satAdd32(input logic [31:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH x WIDTH registers, one write port,
// one asynchronous read port. Contents are deliberately never reset.
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer with valid/ready on both sides and a flush
// that discards every entry. Define FETCH_QUEUE_STATS_EN to add stall/flush counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = FQ_DEPTH,
    parameter int INSTR_W = INSTR_LEN,
    parameter int PC_W    = WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              flushed_entries
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = INSTR_W + PC_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [EW-1:0] head;

    // Full/empty come from the count register alone, so neither handshake
    // output has a combinational path from any input.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_storage (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({in_instr, in_pc}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head)
    );

    // Stale storage is masked so decode never sees leftovers from a flushed path.
    assign out_instr = out_valid ? head[EW-1:PC_W] : '0;
    assign out_pc    = out_valid ? head[PC_W-1:0]  : '0;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flushed_q, flushed_d;

    always_comb begin
        stall_d   = stall_q;
        flushed_d = flushed_q;
        if (in_valid && !in_ready) stall_d = satAdd32(stall_q, 32'd1);
        if (flush)                 flushed_d = satAdd32(flushed_q, 32'(count_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign flushed_entries = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [CW-1:0]      count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]        stall_cycles;
    logic [31:0]        flushed_entries;
`endif

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flushed_entries (flushed_entries)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a plain FIFO of {instr, pc} plus the two statistics totals.
    logic [INSTR_W+PC_W-1:0] model[$];
    longint modelStall   = 0;
    longint modelFlushed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edge as the DUT, using the inputs it saw.
    always @(posedge clk) begin
        if (reset) begin
            model.delete();
            modelStall   = 0;
            modelFlushed = 0;
        end else begin
            bit full;
            full = (model.size() >= DEPTH);
            if (in_valid && full) modelStall++;
            if (flush) begin
                modelFlushed += model.size();
                model.delete();
            end else begin
                bit doPop;
                bit doPush;
                doPop  = (model.size() > 0) && out_ready;
                doPush = in_valid && !full;
                if (doPop) void'(model.pop_front());
                if (doPush) model.push_back({in_instr, in_pc});
            end
        end
    end

    // Every cycle, compare the settled DUT outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [INSTR_W+PC_W-1:0] head;
            head = (model.size() > 0) ? model[0] : '0;
            checkOutput("model.count", 64'(count), 64'(model.size()));
            checkOutput("model.out_valid", 64'(out_valid), 64'(model.size() != 0));
            checkOutput("model.in_ready", 64'(in_ready), 64'(model.size() < DEPTH));
            checkOutput("model.out_instr", 64'(out_instr), 64'(head[INSTR_W+PC_W-1:PC_W]));
            checkOutput("model.out_pc", out_pc, head[PC_W-1:0]);
`ifdef FETCH_QUEUE_STATS_EN
            checkOutput("model.stall_cycles", 64'(stall_cycles), 64'(modelStall));
            checkOutput("model.flushed_entries", 64'(flushed_entries), 64'(modelFlushed));
`endif
        end
    end

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit iv,
                                 input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] pc,
                                 input bit ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PC_W-1:0] received[$];
        int sent;
        int budget;

        reset = 1; flush = 0; in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 0;
        applyStimulus(1, 0, 0, '0, '0, 0);
        applyStimulus(1, 0, 0, '0, '0, 0);
        checkEn = 1;

        // Reset state and first push latency.
        applyStimulus(0, 0, 0, '0, '0, 0);
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset.count", 64'(count), 64'd0);
        checkOutput("reset.out_pc", out_pc, 64'd0);
        applyStimulus(0, 0, 1, 32'h8B020020, 64'd0, 0);
        checkOutput("first.out_valid", 64'(out_valid), 64'd1);
        checkOutput("first.out_instr", 64'(out_instr), 64'h8B020020);
        checkOutput("first.out_pc", out_pc, 64'd0);
        checkOutput("first.count", 64'(count), 64'd1);
        applyStimulus(0, 1, 0, '0, '0, 0);

        // Fill to full, refuse a fifth offer, then drain in order.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'hA000 + i, 64'(i * 4), 0);
        checkOutput("full.count", 64'(count), 64'd4);
        checkOutput("full.in_ready", 64'(in_ready), 64'd0);
        applyStimulus(0, 0, 1, 32'hA004, 64'd16, 0);
        checkOutput("full.reject_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain.out_pc", out_pc, 64'(i * 4));
            applyStimulus(0, 0, 0, '0, '0, 1);
        end
        checkOutput("drain.count", 64'(count), 64'd0);

        // Full plus pop: only the pop happens; the following push+pop holds count.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'hB000 + i, 64'(100 + i * 4), 0);
        applyStimulus(0, 0, 1, 32'hB004, 64'd116, 1);
        checkOutput("fullpop.count", 64'(count), 64'd3);
        checkOutput("fullpop.out_pc", out_pc, 64'd104);
        applyStimulus(0, 0, 1, 32'hB005, 64'd120, 1);
        checkOutput("pushpop.count", 64'(count), 64'd3);
        checkOutput("pushpop.out_pc", out_pc, 64'd108);

        // Flush beats concurrent push and pop; next push becomes the head.
        applyStimulus(0, 1, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'hC000 + i, 64'(i * 4), 0);
        applyStimulus(0, 1, 1, 32'hC003, 64'd12, 1);
        checkOutput("flush.count", 64'(count), 64'd0);
        checkOutput("flush.out_valid", 64'(out_valid), 64'd0);
        applyStimulus(0, 0, 1, 32'hC004, 64'd40, 0);
        checkOutput("flush.head_pc", out_pc, 64'd40);
        checkOutput("flush.head_instr", 64'(out_instr), 64'hC004);
        applyStimulus(0, 1, 0, '0, '0, 0);

        // Ten entries through with random pops so both pointers wrap.
        sent = 0;
        budget = 0;
        while (received.size() < 10 && budget < 200) begin
            bit iv;
            bit ordy;
            iv   = (sent < 10);
            ordy = 1'($urandom_range(0, 1));
            reset = 0; flush = 0; in_valid = iv; in_instr = 32'hD000 + sent;
            in_pc = 64'(sent * 4); out_ready = ordy;
            #1;
            if (out_valid && ordy) received.push_back(out_pc);
            if (iv && in_ready) sent++;
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("wrap.received", 64'(received.size()), 64'd10);
        for (int i = 0; i < received.size(); i++) checkOutput("wrap.order", received[i], 64'(i * 4));

`ifdef FETCH_QUEUE_STATS_EN
        // Three stalled offers against a full queue, then a flush of four entries.
        applyStimulus(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'hE000 + i, 64'(i * 4), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'hE004, 64'd16, 0);
        applyStimulus(0, 1, 0, '0, '0, 0);
        checkOutput("stats.stall_cycles", 64'(stall_cycles), 64'd3);
        checkOutput("stats.flushed_entries", 64'(flushed_entries), 64'd4);
        applyStimulus(1, 0, 0, '0, '0, 0);
        checkOutput("stats.reset_stall", 64'(stall_cycles), 64'd0);
        checkOutput("stats.reset_flushed", 64'(flushed_entries), 64'd0);
`endif

        // Randomized traffic with occasional flushes and mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom,
                          {$urandom, $urandom},
                          $urandom_range(0, 2) != 0);
        end

        applyStimulus(0, 0, 0, '0, '0, 0);
        @(negedge clk);
        checkEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage of the LEGv8 five-stage pipeline.
- Holds up to DEPTH fetched {instruction, PC} pairs so fetch can run ahead while decode stalls.
- Drops all buffered entries on a taken branch (pc_src flush) so wrong-path instructions never reach decode.
- Valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- INSTR_W, 32, instruction width (`INSTR_LEN).
- PC_W, 64, PC width (`WORD).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (driven by pc_src).
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue accepts an entry; equals (count < DEPTH).
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry available to decode; equals (count != 0).
- out_ready  in  1  decode consumes the head this cycle.
- out_instr  out  INSTR_W  head instruction; all zeros when out_valid=0.
- out_pc  out  PC_W  head PC; all zeros when out_valid=0.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset:
  - Applies on the clk edge while reset=1 (synchronous).
  - Clears count, wr_ptr and rd_ptr to 0, so out_valid=0, out_instr=0, out_pc=0 and in_ready=1.
  - Storage contents are not cleared.
  - Reset asserted mid-stream discards every entry, the same as a flush.
- Push and pop:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - Push writes mem[wr_ptr]; wr_ptr advances by 1 modulo DEPTH.
  - Pop advances rd_ptr by 1 modulo DEPTH.
  - count changes by +1 on push only, -1 on pop only, and is unchanged on push and pop together.
- Latency:
  - An entry pushed into an empty queue at edge N is visible on out_* and out_valid from just after edge N.
  - There is no same-cycle bypass from in_* to out_*.
- Full:
  - in_ready=0 whenever count==DEPTH, even if a pop happens in the same cycle; there is no full-pop-push bypass.
  - in_instr and in_pc are ignored while in_ready=0.
- Empty: out_valid=0; out_ready is ignored and count never underflows.
- Ordering: strict FIFO order; PCs leave in the order they were accepted.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - The next edge sets count=0 and rd_ptr=wr_ptr=0, and the concurrent input entry is dropped.
  - in_ready is still driven as (count < DEPTH) during a flush cycle; fetch treats the entry as discarded.
- Reset priority: reset takes priority over flush; both give the same resulting state.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally; full and empty are decided by count alone.
- Registered state: the output data is a combinational read of mem[rd_ptr] gated by out_valid; out_valid and in_ready depend only on the count register.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- When defined, two extra output ports are added:
  - stall_cycles (32): increments each cycle with in_valid=1 and in_ready=0.
  - flushed_entries (32): increments by the pre-flush count on each flush cycle.
- Both counters saturate at 2^32-1 and are cleared by reset.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared definitions header (definitions.vh) supplies `INSTR_LEN and `WORD; it gains `FQ_DEPTH (default queue depth).
- One sub-module: fq_storage, a DEPTH x (INSTR_W+PC_W) register array with one write port and one asynchronous read port.
- Pointers, count, handshake and flush logic stay in fetch_queue.

Test Plan:
- Reset → out_valid=0, in_ready=1, count=0, out_pc=0. Then push {instr 0x8B020020, pc 0} → next cycle out_valid=1, out_instr=0x8B020020, out_pc=0, count=1.
- Out_ready=0; push pc 0,4,8,12 on consecutive cycles → count=4, in_ready=0. Fifth offer pc 16 is not accepted. Then pop four times → out_pc reads 0,4,8,12 in order; count returns to 0.
- Full queue; in_valid=1 and out_ready=1 for one cycle → pop only, count 4→3. Next cycle push is accepted and count stays 3.
- Queue holding pc 0,4,8 with flush=1, in_valid=1 (pc 12) and out_ready=1 → next cycle count=0, out_valid=0. Next push pc 40 appears as the head.
- Ten pushes with pops interleaved to force pointer wrap (DEPTH=4) → output PCs exactly match input order 0..36 step 4.
- With FETCH_QUEUE_STATS_EN: fill to 4, hold in_valid=1 for 3 cycles, then flush → stall_cycles=3, flushed_entries=4. Reset → both 0.
